// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order write-back stage and the MDU.
// MDU results wait in a small FIFO, drain into idle slots, and force a stall when starved.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW_in,
  input  logic [4:0]  RdW_in,
  input  logic [31:0] ResultW_in,
  input  logic        mdu_valid_in,
  input  logic [4:0]  mdu_rd_in,
  input  logic [31:0] mdu_result_in,
  output logic        mdu_ready_out,
  input  logic [4:0]  rs1D_in,
  input  logic [4:0]  rs2D_in,
  output logic        pending_hit_out,
  output logic        stall_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_q   [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic fifo_empty;
  logic head_live;
  logic pipe_eff;
  logic stall_c;
  logic pipe_wr;
  logic pop;
  logic push;
  logic ready_c;
  logic hit_c;

  // Port grant: forced drain, then pipeline, then opportunistic drain.
  always_comb begin
    fifo_empty = (count_q == '0);
    head_live  = !fifo_empty && live_q[rd_ptr_q];
    pipe_eff   = RegWriteW_in && (RdW_in != 5'd0);
    stall_c    = rst_n && head_live && (starve_q == SW'(STARVE_LIMIT));
    pipe_wr    = rst_n && pipe_eff && !stall_c;
    // A killed head pops silently even while the pipeline owns the port.
    pop        = rst_n && !fifo_empty && (stall_c || !pipe_eff || !head_live);
    ready_c    = rst_n && (count_q < CNTW'(DEPTH));
    push       = mdu_valid_in && ready_c && (mdu_rd_in != 5'd0);
  end

  always_comb begin
    rf_we_out    = 1'b0;
    rf_waddr_out = 5'd0;
    rf_wdata_out = 32'd0;
    if (pipe_wr) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = RdW_in;
      rf_wdata_out = ResultW_in;
    end else if (pop && head_live) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = rd_q[rd_ptr_q];
      rf_wdata_out = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[AW'(i)] &&
          (((rs1D_in != 5'd0) && (rd_q[AW'(i)] == rs1D_in)) ||
           ((rs2D_in != 5'd0) && (rd_q[AW'(i)] == rs2D_in)))) begin
        hit_c = 1'b1;
      end
    end
  end

  assign mdu_ready_out   = ready_c;
  assign stall_out       = stall_c;
  assign pending_hit_out = rst_n && hit_c;

  // Next-state: live bits, pointers, occupancy and starvation counter.
  always_comb begin
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end
    if (pipe_wr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_q[AW'(i)] == RdW_in) begin
          live_d[AW'(i)] = 1'b0;
        end
      end
    end
    // Applied after the kill: a same-cycle MDU result is the younger write.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (head_live && pipe_wr && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage; validity is carried solely by live_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= mdu_rd_in;
      data_q[wr_ptr_q] <= mdu_result_in;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle vector table plus a hand-written
// backpressure sequence.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW_in;
  logic [4:0]  RdW_in;
  logic [31:0] ResultW_in;
  logic        mdu_valid_in;
  logic [4:0]  mdu_rd_in;
  logic [31:0] mdu_result_in;
  logic        mdu_ready_out;
  logic [4:0]  rs1D_in, rs2D_in;
  logic        pending_hit_out;
  logic        stall_out;
  logic        rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RegWriteW_in   (RegWriteW_in),
    .RdW_in         (RdW_in),
    .ResultW_in     (ResultW_in),
    .mdu_valid_in   (mdu_valid_in),
    .mdu_rd_in      (mdu_rd_in),
    .mdu_result_in  (mdu_result_in),
    .mdu_ready_out  (mdu_ready_out),
    .rs1D_in        (rs1D_in),
    .rs2D_in        (rs2D_in),
    .pending_hit_out(pending_hit_out),
    .stall_out      (stall_out),
    .rf_we_out      (rf_we_out),
    .rf_waddr_out   (rf_waddr_out),
    .rf_wdata_out   (rf_wdata_out)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_hit;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic we, input logic [4:0] rd, input logic [31:0] res,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                     input logic e_rdy, input logic e_hit, input logic e_stall);
    vec_t v;
    v.rst = rst; v.we = we; v.rd = rd; v.res = res;
    v.mv = mv; v.mrd = mrd; v.mres = mres; v.rs1 = rs1; v.rs2 = rs2;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic drive(input logic rst, input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    @(negedge clk);
    rst_n = rst; RegWriteW_in = we; RdW_in = rd; ResultW_in = res;
    mdu_valid_in = mv; mdu_rd_in = mrd; mdu_result_in = mres;
    rs1D_in = rs1; rs2D_in = rs2;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0; RegWriteW_in = 1'b0; RdW_in = '0; ResultW_in = '0;
    mdu_valid_in = 1'b0; mdu_rd_in = '0; mdu_result_in = '0;
    rs1D_in = '0; rs2D_in = '0;

    //   rst we rd res          mv mrd mres         rs1 rs2 | we addr data        rdy hit stall
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        0,  0,  0);
    add(0, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        0,  0,  0);
    // MDU push drains into the next idle slot
    add(1, 0, 0, 32'h0,        1, 5,  32'h0000_00AA, 5, 0,   0, 0,  32'h0,        1,  0,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        5,  0,   1, 5,  32'h0000_00AA, 1, 1,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        5,  0,   0, 0,  32'h0,        1,  0,  0);
    // Starvation: four pipeline writes, forced drain, then the held write
    add(1, 0, 0, 32'h0,        1, 7,  32'h77,       0,  0,   0, 0,  32'h0,        1,  0,  0);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        0,  0,   1, 3,  32'h33,       1,  0,  0);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        0,  0,   1, 3,  32'h33,       1,  0,  0);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        0,  0,   1, 3,  32'h33,       1,  0,  0);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        0,  0,   1, 3,  32'h33,       1,  0,  0);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        7,  0,   1, 7,  32'h77,       1,  1,  1);
    add(1, 1, 3, 32'h33,       0, 0,  32'h0,        7,  0,   1, 3,  32'h33,       1,  0,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        1,  0,  0);
    // WAW kill of a buffered result
    add(1, 0, 0, 32'h0,        1, 9,  32'h11,       0,  0,   0, 0,  32'h0,        1,  0,  0);
    add(1, 1, 9, 32'h22,       0, 0,  32'h0,        9,  0,   1, 9,  32'h22,       1,  1,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        9,  0,   0, 0,  32'h0,        1,  0,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        9,  9,   0, 0,  32'h0,        1,  0,  0);
    // Pending-hit reporting and rd=0 MDU push
    add(1, 0, 0, 32'h0,        1, 12, 32'h0C,       0,  12,  0, 0,  32'h0,        1,  0,  0);
    add(1, 1, 1, 32'h1,        0, 0,  32'h0,        12, 0,   1, 1,  32'h1,        1,  1,  0);
    add(1, 0, 0, 32'h0,        1, 0,  32'hDEAD,     0,  0,   1, 12, 32'h0C,       1,  0,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        1,  0,  0);
    add(1, 1, 0, 32'h55,       0, 0,  32'h0,        0,  0,   0, 0,  32'h0,        1,  0,  0);
    // Reset with two entries buffered
    add(1, 1, 2, 32'h2,        1, 20, 32'h14,       0,  0,   1, 2,  32'h2,        1,  0,  0);
    add(1, 1, 2, 32'h2,        1, 21, 32'h15,       20, 0,   1, 2,  32'h2,        1,  1,  0);
    add(0, 1, 2, 32'h2,        1, 22, 32'h16,       20, 21,  0, 0,  32'h0,        0,  0,  0);
    add(1, 0, 0, 32'h0,        0, 0,  32'h0,        20, 21,  0, 0,  32'h0,        1,  0,  0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].res, vecs[i].mv, vecs[i].mrd,
            vecs[i].mres, vecs[i].rs1, vecs[i].rs2);
      chk($sformatf("v%0d.we", i), 32'(rf_we_out), 32'(vecs[i].e_we));
      chk($sformatf("v%0d.ready", i), 32'(mdu_ready_out), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.hit", i), 32'(pending_hit_out), 32'(vecs[i].e_hit));
      chk($sformatf("v%0d.stall", i), 32'(stall_out), 32'(vecs[i].e_stall));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d.waddr", i), 32'(rf_waddr_out), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d.wdata", i), rf_wdata_out, vecs[i].e_data);
      end
    end

    // Backpressure: FIFO fills while the pipeline writes; third result must wait
    drive(1, 1, 1, 32'h1, 1, 10, 32'hA0, 0, 0);
    chk("bp.push_a_ready", 32'(mdu_ready_out), 32'd1);
    drive(1, 1, 1, 32'h1, 1, 11, 32'hB0, 0, 0);
    chk("bp.push_b_ready", 32'(mdu_ready_out), 32'd1);
    acc = -1;
    for (int n = 0; n < 10; n++) begin
      drive(1, 1, 1, 32'h1, 1, 13, 32'hC0, 0, 0);
      if (n == 0) chk("bp.full_ready", 32'(mdu_ready_out), 32'd0);
      if (n == 3) begin
        chk("bp.stall", 32'(stall_out), 32'd1);
        chk("bp.stall_waddr", 32'(rf_waddr_out), 32'd10);
        chk("bp.stall_wdata", rf_wdata_out, 32'hA0);
      end
      if (mdu_ready_out) begin
        acc = n;
        break;
      end
    end
    chk("bp.accept_cycle", 32'(acc), 32'd4);
    chk("bp.accept_pipe_waddr", 32'(rf_waddr_out), 32'd1);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    chk("bp.drain_b_we", 32'(rf_we_out), 32'd1);
    chk("bp.drain_b_waddr", 32'(rf_waddr_out), 32'd11);
    chk("bp.drain_b_wdata", rf_wdata_out, 32'hB0);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 13, 0);
    chk("bp.drain_c_waddr", 32'(rf_waddr_out), 32'd13);
    chk("bp.drain_c_wdata", rf_wdata_out, 32'hC0);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 13, 0);
    chk("bp.empty_we", 32'(rf_we_out), 32'd0);
    chk("bp.empty_hit", 32'(pending_hit_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
